// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART command-frame deframer.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        CMD,
        LEN,
        PAYLOAD,
        CSUM
    } state_t;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_CSUM    = 3'd1;
    localparam logic [2:0] ERR_LEN     = 3'd2;
    localparam logic [2:0] ERR_UART    = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT = 3'd4;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_frame_timeout.sv
// Inter-byte watchdog: down-counter reloaded by clr, decremented by en.
// expire is a combinational 1-cycle pulse when an enabled count sits at zero.
module uart_frame_timeout #(
    parameter int unsigned LOAD_VAL = 71_999
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int W = (LOAD_VAL > 0) ? $clog2(LOAD_VAL + 1) : 1;

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = W'(LOAD_VAL);
        end else if (en && count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    assign expire = en && !clr && (count_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_frame_parser.sv
// Deframes SYNC,CMD,LEN,PAYLOAD[LEN],CSUM from a UART byte stream; no backpressure.
// Every output event is registered and appears 1 clk after the causing input.
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int          MAX_LEN        = 32,
    parameter int          TIMEOUT_CYCLES = 72_000,
    localparam int         IW             = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    input  logic          rx_error,
    output logic [7:0]    cmd_out,
    output logic [7:0]    len_out,
    output logic [7:0]    payload_data,
    output logic          payload_valid,
    output logic [IW-1:0] payload_index,
    output logic          frame_valid,
    output logic          frame_error,
    output logic [2:0]    err_code
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t        state_q, state_d;
    logic [7:0]    cmd_q, cmd_d, len_q, len_d, sum_q, sum_d, cnt_q, cnt_d;
    logic [7:0]    pdat_q, pdat_d;
    logic [IW-1:0] pidx_q, pidx_d;
    logic          pvld_q, pvld_d, fvld_q, fvld_d, ferr_q, ferr_d;
    logic [2:0]    err_q, err_d;
    logic          tmo_expire;

    uart_frame_timeout #(
        .LOAD_VAL (TIMEOUT_CYCLES - 1)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (rx_valid || state_q == IDLE),
        .en     (state_q != IDLE),
        .expire (tmo_expire)
    );

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        len_d   = len_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        pdat_d  = pdat_q;
        pidx_d  = pidx_q;
        err_d   = err_q;
        pvld_d  = 1'b0;
        fvld_d  = 1'b0;
        ferr_d  = 1'b0;

        if (state_q != IDLE && rx_error) begin
            ferr_d  = 1'b1;
            err_d   = ERR_UART;
            state_d = IDLE;
        end else if (rx_valid && !rx_error) begin
            case (state_q)
                IDLE: begin
                    if (rx_data == SYNC_BYTE) state_d = SYNC;
                end
                // SYNC normally falls through to CMD; a byte arriving while still in SYNC is the CMD byte.
                SYNC, CMD: begin
                    cmd_d   = rx_data;
                    sum_d   = rx_data;
                    state_d = LEN;
                end
                LEN: begin
                    len_d = rx_data;
                    sum_d = sum_q + rx_data;
                    cnt_d = '0;
                    if (rx_data > MAX_LEN_B) begin
                        ferr_d  = 1'b1;
                        err_d   = ERR_LEN;
                        state_d = IDLE;
                    end else if (rx_data == 8'd0) begin
                        state_d = CSUM;
                    end else begin
                        state_d = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    pvld_d = 1'b1;
                    pdat_d = rx_data;
                    pidx_d = cnt_q[IW-1:0];
                    sum_d  = sum_q + rx_data;
                    cnt_d  = cnt_q + 8'd1;
                    if (cnt_q == len_q - 8'd1) state_d = CSUM;
                end
                CSUM: begin
                    if (rx_data == sum_q) begin
                        fvld_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                        err_d  = ERR_CSUM;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (tmo_expire) begin
            ferr_d  = 1'b1;
            err_d   = ERR_TIMEOUT;
            state_d = IDLE;
        end else if (state_q == SYNC) begin
            state_d = CMD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            len_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            pdat_q  <= '0;
            pidx_q  <= '0;
            pvld_q  <= 1'b0;
            fvld_q  <= 1'b0;
            ferr_q  <= 1'b0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            len_q   <= len_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            pdat_q  <= pdat_d;
            pidx_q  <= pidx_d;
            pvld_q  <= pvld_d;
            fvld_q  <= fvld_d;
            ferr_q  <= ferr_d;
            err_q   <= err_d;
        end
    end

    assign cmd_out       = cmd_q;
    assign len_out       = len_q;
    assign payload_data  = pdat_q;
    assign payload_valid = pvld_q;
    assign payload_index = pidx_q;
    assign frame_valid   = fvld_q;
    assign frame_error   = ferr_q;
    assign err_code      = err_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser: events are queued as stimulus is driven
// and matched in order as the parser emits them.
module tb_uart_frame_parser;

    localparam int MAX_LEN = 32;
    localparam int TMO     = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic       rx_error = 1'b0;
    logic [7:0] cmd_out, len_out, payload_data;
    logic       payload_valid, frame_valid, frame_error;
    logic [4:0] payload_index;
    logic [2:0] err_code;

    typedef struct packed {
        logic [1:0] kind;  // 0 payload, 1 commit, 2 abort
        logic [7:0] dat;   // payload byte, or error code for an abort
        logic [7:0] idx;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    uart_frame_parser #(
        .SYNC_BYTE      (8'hA5),
        .MAX_LEN        (MAX_LEN),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_error      (rx_error),
        .cmd_out       (cmd_out),
        .len_out       (len_out),
        .payload_data  (payload_data),
        .payload_valid (payload_valid),
        .payload_index (payload_index),
        .frame_valid   (frame_valid),
        .frame_error   (frame_error),
        .err_code      (err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_pl(input logic [7:0] d, input logic [7:0] i);
        sb.push_back('{kind: 2'd0, dat: d, idx: i});
    endtask

    task automatic push_ok();
        sb.push_back('{kind: 2'd1, dat: 8'd0, idx: 8'd0});
    endtask

    task automatic push_err(input logic [7:0] code);
        sb.push_back('{kind: 2'd2, dat: code, idx: 8'd0});
    endtask

    task automatic drive(input logic [7:0] b, input logic v, input logic e);
        @(posedge clk); #1;
        rx_data  = b;
        rx_valid = v;
        rx_error = e;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_error = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        drive(b, 1'b1, 1'b0);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) begin
            @(negedge clk); #1;
        end
        chk("drain", sb.size(), 0);
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] len,
                              input logic [7:0] seed, input bit bad);
        logic [7:0] s, b;
        s = cmd + len;
        send_byte(8'hA5);
        send_byte(cmd);
        send_byte(len);
        for (int i = 0; i < int'(len); i++) begin
            b = seed + 8'(17 * i);
            s = s + b;
            push_pl(b, 8'(i));
            send_byte(b);
        end
        if (bad) begin
            push_err(8'd1);
            send_byte(s + 8'd1);
        end else begin
            push_ok();
            send_byte(s);
        end
        wait_drain(10);
        chk("cmd_out", cmd_out, cmd);
        chk("len_out", len_out, len);
    endtask

    always @(negedge clk) begin : monitor
        exp_t       e;
        logic [1:0] kind;
        if (!rst) begin
            if (frame_valid && frame_error) chk("commit_abort_overlap", 1, 0);
            if (payload_valid && (frame_valid || frame_error)) chk("payload_end_overlap", 1, 0);
            if (payload_valid || frame_valid || frame_error) begin
                kind = payload_valid ? 2'd0 : (frame_valid ? 2'd1 : 2'd2);
                if (sb.size() == 0) begin
                    chk("unexpected_event", 32'(kind), 32'hFF);
                end else begin
                    e = sb.pop_front();
                    chk("event_kind", 32'(kind), 32'(e.kind));
                    if (kind == 2'd0) begin
                        chk("payload_data", payload_data, e.dat);
                        chk("payload_index", payload_index, e.idx);
                    end else if (kind == 2'd2) begin
                        chk("err_code", err_code, e.dat);
                    end
                end
            end
        end
    end

    initial begin
        #800_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        chk("rst_cmd", cmd_out, 0);
        chk("rst_len", len_out, 0);
        chk("rst_pvld", payload_valid, 0);
        chk("rst_fvld", frame_valid, 0);
        chk("rst_ferr", frame_error, 0);
        chk("rst_err", err_code, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Good frame, then bad checksum followed by recovery
        send_frame(8'h10, 8'd2, 8'h11, 1'b0);
        send_frame(8'h10, 8'd2, 8'h11, 1'b1);
        send_frame(8'h10, 8'd2, 8'h11, 1'b0);

        // Length limit and zero-length frame
        push_err(8'd2);
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h21);
        wait_drain(10);
        chk("len_out_latched", len_out, 8'h21);
        send_frame(8'h10, 8'd0, 8'h00, 1'b0);
        send_frame(8'h7E, 8'd32, 8'h03, 1'b0);

        // Inter-byte timeout, stray bytes in IDLE ignored
        send_byte(8'hA5); send_byte(8'h10);
        push_err(8'd4);
        repeat (TMO - 10) @(negedge clk);
        #1 chk("timeout_not_early", sb.size(), 1);
        wait_drain(40);
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h33);
        drive(8'h00, 1'b0, 1'b1);
        send_frame(8'h42, 8'd3, 8'h5A, 1'b0);

        // UART error alone mid-payload, then together with a byte
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h03);
        push_pl(8'h11, 8'd0); send_byte(8'h11);
        push_err(8'd3); drive(8'h22, 1'b0, 1'b1);
        send_byte(8'h33);
        wait_drain(10);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h03);
        push_pl(8'h11, 8'd0); send_byte(8'h11);
        push_err(8'd3); drive(8'h22, 1'b1, 1'b1);
        wait_drain(10);
        send_frame(8'hA5, 8'd4, 8'hA5, 1'b0);

        // Asynchronous reset mid-payload
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h03);
        push_pl(8'h11, 8'd0); send_byte(8'h11);
        wait_drain(10);
        chk("pre_rst_pdat", payload_data, 8'h11);
        @(posedge clk); #3 rst = 1'b1;
        #1;
        chk("async_rst_cmd", cmd_out, 0);
        chk("async_rst_len", len_out, 0);
        chk("async_rst_pdat", payload_data, 0);
        chk("async_rst_err", err_code, 0);
        @(posedge clk); #1 rst = 1'b0;
        send_frame(8'h10, 8'd2, 8'h11, 1'b0);

        // A few random frames
        for (int k = 0; k < 4; k++) begin
            send_frame(8'($urandom_range(0, 255)), 8'($urandom_range(1, MAX_LEN)),
                       8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end

        repeat (5) @(posedge clk);
        chk("final_queue_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
